// File: rtl/rs_issue_select_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rs_issue_select_pkg
//  Brief    : Shared sizing constants and types for the RS issue-select lane.
//  Revision : 1.0 - initial release
// ============================================================================
package rs_issue_select_pkg;

  // Default number of reservation-station entries feeding one FU lane.
  localparam int ISSUE_N     = 8;
  localparam int ISSUE_IDX_W = $clog2(ISSUE_N);

  // Entry index and per-entry one-hot vector at the default size.
  typedef logic [ISSUE_IDX_W-1:0] issue_idx_t;
  typedef logic [ISSUE_N-1:0]     onehot_t;

endpackage : rs_issue_select_pkg
`default_nettype wire

// File: rtl/rs_issue_select_rot_prio_pick.sv
`default_nettype none
// ============================================================================
//  Module   : rot_prio_pick
//  Brief    : Combinational rotating-priority picker. Searches the candidate
//             vector upward from the priority pointer, wrapping at N-1 to 0,
//             and returns the first set entry as index and one-hot.
//  Revision : 1.0 - initial release
// ============================================================================
module rot_prio_pick
  import rs_issue_select_pkg::*;
#(
  parameter int N     = ISSUE_N,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     cand_i,
  input  logic [IDX_W-1:0] rot_ptr_i,
  output logic [IDX_W-1:0] winner_o,
  output logic [N-1:0]     winner_oh_o,
  output logic             any_o
);

  logic             w_found;
  logic [IDX_W-1:0] w_idx;

  assign any_o = |cand_i;

  // Walk the entries in priority order; N is a power of two so the index
  // addition wraps at N-1 back to 0 on its own.
  always_comb begin
    w_found  = 1'b0;
    w_idx    = '0;
    winner_o = '0;
    for (int k = 0; k < N; k++) begin
      w_idx = rot_ptr_i + IDX_W'(k);
      if (!w_found && cand_i[w_idx]) begin
        w_found  = 1'b1;
        winner_o = w_idx;
      end
    end
  end

  // One-hot form of the winner, all-zero when nothing is a candidate.
  for (genvar j = 0; j < N; j++) begin : g_oh
    assign winner_oh_o[j] = any_o && (winner_o == IDX_W'(j));
  end

endmodule : rot_prio_pick
`default_nettype wire

// File: rtl/rs_issue_select.sv
`default_nettype none
// ============================================================================
//  Module   : rs_issue_select
//  Brief    : Issue-select stage for one FU lane. Picks one ready RS entry per
//             cycle with a rotating priority pointer, registers it toward the
//             FU under valid/ready, and pulses a one-hot acknowledge so the RS
//             can clear the issued entry.
//  Config   : ISSUE_ROTATE_EN - when defined the priority pointer advances to
//             winner+1 on every load (round-robin); otherwise it stays at 0
//             (fixed priority, lowest index wins).
//  Revision : 1.0 - initial release
// ============================================================================
module rs_issue_select
  import rs_issue_select_pkg::*;
#(
  parameter int N     = ISSUE_N,
  parameter int IDX_W = $clog2(N)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N-1:0]     ready_vec,
  input  logic             squash,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_idx,
  output logic [N-1:0]     issue_ack,
  output logic [IDX_W-1:0] rot_ptr
);

  logic             out_valid_q, out_valid_d;
  logic [IDX_W-1:0] out_idx_q,   out_idx_d;
  logic [N-1:0]     issue_ack_q, issue_ack_d;
  logic [IDX_W-1:0] rot_ptr_q,   rot_ptr_d;

  logic [N-1:0]     w_cand;
  logic [IDX_W-1:0] w_winner;
  logic [N-1:0]     w_winner_oh;
  logic             w_any;
  logic             w_load;

  // The entry acknowledged last edge is still set in ready_vec while the RS
  // clears it, so it must not be picked a second time.
  assign w_cand = ready_vec & ~issue_ack_q;

  rot_prio_pick #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_pick (
    .cand_i      (w_cand),
    .rot_ptr_i   (rot_ptr_q),
    .winner_o    (w_winner),
    .winner_oh_o (w_winner_oh),
    .any_o       (w_any)
  );

  // Capture only when the output slot is empty or being drained this cycle.
  assign w_load = !squash && w_any && (!out_valid_q || out_ready);

  // Next-state: squash wins, then a new capture, otherwise drain or hold.
  always_comb begin
    out_valid_d = out_valid_q;
    out_idx_d   = out_idx_q;
    issue_ack_d = '0;
    rot_ptr_d   = rot_ptr_q;
    if (squash) begin
      out_valid_d = 1'b0;
    end else if (w_load) begin
      out_valid_d = 1'b1;
      out_idx_d   = w_winner;
      issue_ack_d = w_winner_oh;
`ifdef ISSUE_ROTATE_EN
      rot_ptr_d   = w_winner + IDX_W'(1);
`else
      rot_ptr_d   = '0;
`endif
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      issue_ack_q <= '0;
      rot_ptr_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
      issue_ack_q <= issue_ack_d;
      rot_ptr_q   <= rot_ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_idx   = out_idx_q;
  assign issue_ack = issue_ack_q;
  assign rot_ptr   = rot_ptr_q;

endmodule : rs_issue_select
`default_nettype wire
